axi_master_seq: RTL and testbench
=================================

AXI_MASTER_SEQ -- requirements
Module: axi_master_seq

Interface
REQ-001 SHALL have one clock and one asynchronous, active-high reset; all other ports are listed below.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have port: req_rd  in  1  start read; sampled only in IDLE.
REQ-005 SHALL have port: req_wr  in  1  start write; sampled only in IDLE.
REQ-006 SHALL have port: req_addr  in  4  transaction address.
REQ-007 SHALL have port: req_wdata  in  4  write data.
REQ-008 SHALL have ports: ms_arvalid out 1, ms_araddr out 4, sm_arready in 1  read-address channel.
REQ-009 SHALL have ports: sm_rvalid in 1, sm_rdata in 4, ms_rready out 1  read-data channel.
REQ-010 SHALL have ports: ms_awvalid out 1, ms_awaddr out 4, sm_awready in 1  write-address channel.
REQ-011 SHALL have ports: ms_wvalid out 1, ms_wdata out 4, sm_wready in 1  write-data channel.
REQ-012 SHALL have ports: busy out 1 (not IDLE), done out 1 (1-cycle completion pulse), rd_data out 4 (last read data), err out 1 (sticky timeout flag).

Function
REQ-013 SHALL implement states IDLE, AR, R, W, DONE.
REQ-014 In IDLE with req_rd=1, SHALL latch req_addr and go to AR; ms_arvalid rises the next cycle.
REQ-015 In IDLE with req_wr=1 and req_rd=0, SHALL latch req_addr and req_wdata and go to W; ms_awvalid and ms_wvalid rise together the next cycle.
REQ-016 If req_rd and req_wr are both 1 in IDLE, SHALL perform the read; the write request is dropped.
REQ-017 SHALL ignore req_rd and req_wr in every state other than IDLE.
REQ-018 Once a valid is asserted, SHALL hold it high, with address and data stable, until the cycle in which the matching ready is sampled high.
REQ-019 In AR, a cycle with ms_arvalid=1 and sm_arready=1 SHALL clear ms_arvalid and move to R next cycle.
REQ-020 In R, SHALL hold ms_rready=1; a cycle with sm_rvalid=1 SHALL capture sm_rdata into rd_data, clear ms_rready, and move to DONE.
REQ-021 In W, SHALL complete the AW and W handshakes independently; each valid clears after its own handshake, in the same or different cycles.
REQ-022 SHALL leave W for DONE the cycle after both handshakes have completed; simultaneous completion takes one cycle.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 SHALL hold busy=1 in AR, R, W and DONE, and busy=0 only in IDLE.
REQ-025 Minimum latency SHALL be: read 4 cycles request-to-done with ready/rvalid tied high; write 3 cycles.
REQ-026 SHALL change rd_data only on a read-data capture.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, all valids and ms_rready to 0, busy=0, done=0, err=0, rd_data=0, and latched address/data to 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no done pulse; the first request after release starts cleanly.

Configuration
REQ-029 With macro AXI_MASTER_SEQ_TIMEOUT_EN defined, SHALL run an 8-bit watchdog that clears on state entry and on every handshake, and increments each cycle in AR, R or W.
REQ-030 With AXI_MASTER_SEQ_TIMEOUT_EN defined, watchdog reaching 255 SHALL drop all valids and ms_rready, set err=1 (sticky until reset), and go to DONE; rd_data is unchanged.
REQ-031 Without AXI_MASTER_SEQ_TIMEOUT_EN, SHALL omit the watchdog logic, tie err to 0, and wait indefinitely for ready.

Verification
REQ-032 Read with addr=4'h3, ready and rvalid tied high, sm_rdata=4'hA -> arvalid 1 cycle, rd_data=4'hA, done pulse at cycle 4, err=0.
REQ-033 Write with addr=4'h5, wdata=4'hC, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles with awaddr=4'h5 stable, done one cycle after awready.
REQ-034 req_rd=req_wr=1 in IDLE -> only arvalid asserts, no awvalid/wvalid; a second req_wr issued while busy -> ignored.
REQ-035 Reset pulsed during R with sm_rvalid=0 -> all outputs 0 in the same cycle, no done pulse; a following read completes normally.
REQ-036 With AXI_MASTER_SEQ_TIMEOUT_EN and sm_arready held 0 -> arvalid drops and err=1 after 255 cycles in AR, done pulses once; without the macro, arvalid stays high indefinitely and err stays 0.

Source files
------------

// File: rtl/axi_master_seq.sv
// Single-outstanding AXI-lite style master sequencer: one read (AR then R) or one write (AW+W) per request.
// Optional watchdog timeout enabled by defining AXI_MASTER_SEQ_TIMEOUT_EN.
module axi_master_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_rd,
    input  logic       req_wr,
    input  logic [3:0] req_addr,
    input  logic [3:0] req_wdata,
    output logic       ms_arvalid,
    output logic [3:0] ms_araddr,
    input  logic       sm_arready,
    input  logic       sm_rvalid,
    input  logic [3:0] sm_rdata,
    output logic       ms_rready,
    output logic       ms_awvalid,
    output logic [3:0] ms_awaddr,
    input  logic       sm_awready,
    output logic       ms_wvalid,
    output logic [3:0] ms_wdata,
    input  logic       sm_wready,
    output logic       busy,
    output logic       done,
    output logic [3:0] rd_data,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        W    = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state_r;
    logic [3:0] addr_r;
    logic [3:0] wdata_r;
    logic       arvalid_r;
    logic       rready_r;
    logic       awvalid_r;
    logic       wvalid_r;
    logic       busy_r;
    logic       done_r;
    logic [3:0] rd_data_r;

    logic       ar_hs_s;
    logic       r_hs_s;
    logic       aw_hs_s;
    logic       w_hs_s;
    logic       aw_clear_s;
    logic       w_clear_s;
    logic       timeout_s;

    assign ar_hs_s    = arvalid_r & sm_arready;
    assign r_hs_s     = rready_r & sm_rvalid;
    assign aw_hs_s    = awvalid_r & sm_awready;
    assign w_hs_s     = wvalid_r & sm_wready;
    // A write channel is finished once its valid is low or it handshakes this cycle.
    assign aw_clear_s = ~awvalid_r | aw_hs_s;
    assign w_clear_s  = ~wvalid_r | w_hs_s;

`ifdef AXI_MASTER_SEQ_TIMEOUT_EN
    logic [7:0] wdog_r;
    logic       err_r;
    logic       active_s;
    logic       any_hs_s;

    assign active_s  = (state_r == AR) || (state_r == R) || (state_r == W);
    assign any_hs_s  = ar_hs_s | r_hs_s | aw_hs_s | w_hs_s;
    // Expire on the cycle the counter would reach 255; a handshake in that cycle wins.
    assign timeout_s = active_s & (wdog_r == 8'd254) & ~any_hs_s;

    // Watchdog: zero outside the waiting states and on every handshake, else count up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_r <= 8'd0;
        end else if (!active_s || any_hs_s) begin
            wdog_r <= 8'd0;
        end else if (wdog_r != 8'd255) begin
            wdog_r <= wdog_r + 8'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Main sequencer FSM with registered channel controls and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= 4'd0;
            wdata_r   <= 4'd0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_data_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (req_rd) begin
                        addr_r    <= req_addr;
                        arvalid_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= AR;
                    end else if (req_wr) begin
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= W;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                AR: begin
                    if (timeout_s) begin
                        arvalid_r <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else if (ar_hs_s) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= R;
                    end else begin
                        state_r <= AR;
                    end
                end
                R: begin
                    if (timeout_s) begin
                        rready_r <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else if (r_hs_s) begin
                        rd_data_r <= sm_rdata;
                        rready_r  <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= R;
                    end
                end
                W: begin
                    if (timeout_s) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        if (aw_hs_s) begin
                            awvalid_r <= 1'b0;
                        end else begin
                            awvalid_r <= awvalid_r;
                        end
                        if (w_hs_s) begin
                            wvalid_r <= 1'b0;
                        end else begin
                            wvalid_r <= wvalid_r;
                        end
                        if (aw_clear_s && w_clear_s) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= W;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign ms_arvalid = arvalid_r;
    assign ms_araddr  = addr_r;
    assign ms_rready  = rready_r;
    assign ms_awvalid = awvalid_r;
    assign ms_awaddr  = addr_r;
    assign ms_wvalid  = wvalid_r;
    assign ms_wdata   = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_axi_master_seq.sv
// Directed self-checking bench for axi_master_seq; timeout scenario follows AXI_MASTER_SEQ_TIMEOUT_EN.
module tb_axi_master_seq;

    logic       clk;
    logic       reset;
    logic       req_rd;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [3:0] req_wdata;
    logic       ms_arvalid;
    logic [3:0] ms_araddr;
    logic       sm_arready;
    logic       sm_rvalid;
    logic [3:0] sm_rdata;
    logic       ms_rready;
    logic       ms_awvalid;
    logic [3:0] ms_awaddr;
    logic       sm_awready;
    logic       ms_wvalid;
    logic [3:0] ms_wdata;
    logic       sm_wready;
    logic       busy;
    logic       done;
    logic [3:0] rd_data;
    logic       err;

    int n_cmp;
    int n_bad;

    axi_master_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ms_arvalid (ms_arvalid),
        .ms_araddr  (ms_araddr),
        .sm_arready (sm_arready),
        .sm_rvalid  (sm_rvalid),
        .sm_rdata   (sm_rdata),
        .ms_rready  (ms_rready),
        .ms_awvalid (ms_awvalid),
        .ms_awaddr  (ms_awaddr),
        .sm_awready (sm_awready),
        .ms_wvalid  (ms_wvalid),
        .ms_wdata   (ms_wdata),
        .sm_wready  (sm_wready),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] all_outs();
        return {ms_arvalid, ms_araddr, ms_rready, ms_awvalid, ms_awaddr,
                ms_wvalid, ms_wdata, busy, done, rd_data, err};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            $display("FAIL reset_outputs got=%h exp=%h", all_outs(), 23'd0);
            n_bad++;
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({busy, done, ms_arvalid, ms_awvalid} !== 4'b0000) begin
            $display("FAIL reset_idle got=%b exp=0000", {busy, done, ms_arvalid, ms_awvalid});
            n_bad++;
        end
    endtask

    // Read, all readies tied high: AR cycle 1, R cycle 2, DONE cycle 3.
    task automatic test_read();
        sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'hA;
        req_rd = 1'b1; req_addr = 4'h3;
        tick();
        req_rd = 1'b0; req_addr = 4'h0;
        n_cmp++;
        if ({ms_arvalid, ms_araddr, ms_rready, busy, done} !== 8'b1_0011_0_1_0) begin
            $display("FAIL read_ar got=%b exp=%b", {ms_arvalid, ms_araddr, ms_rready, busy, done}, 8'b1_0011_0_1_0);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({ms_arvalid, ms_rready, busy, done} !== 4'b0110) begin
            $display("FAIL read_r got=%b exp=0110", {ms_arvalid, ms_rready, busy, done});
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({ms_rready, busy, done, rd_data, err} !== 8'b0_1_1_1010_0) begin
            $display("FAIL read_done got=%b exp=%b", {ms_rready, busy, done, rd_data, err}, 8'b0_1_1_1010_0);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({busy, done, rd_data} !== 6'b00_1010) begin
            $display("FAIL read_idle got=%b exp=001010", {busy, done, rd_data});
            n_bad++;
        end
    endtask

    // Write with AW ready delayed to the third valid cycle, W ready immediate.
    task automatic test_write_delayed();
        sm_awready = 1'b0; sm_wready = 1'b1;
        req_wr = 1'b1; req_addr = 4'h5; req_wdata = 4'hC;
        tick();
        req_wr = 1'b0; req_addr = 4'h0; req_wdata = 4'h0;
        n_cmp++;
        if ({ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_arvalid} !== 11'b1_0101_1_1100_0) begin
            $display("FAIL write_c1 got=%b exp=%b", {ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_arvalid}, 11'b1_0101_1_1100_0);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({ms_awvalid, ms_awaddr, ms_wvalid, done} !== 7'b1_0101_0_0) begin
            $display("FAIL write_c2 got=%b exp=%b", {ms_awvalid, ms_awaddr, ms_wvalid, done}, 7'b1_0101_0_0);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({ms_awvalid, ms_awaddr, done} !== 6'b1_0101_0) begin
            $display("FAIL write_c3 got=%b exp=%b", {ms_awvalid, ms_awaddr, done}, 6'b1_0101_0);
            n_bad++;
        end
        sm_awready = 1'b1;
        tick();
        n_cmp++;
        if ({ms_awvalid, ms_wvalid, busy, done, rd_data} !== 8'b0_0_1_1_1010) begin
            $display("FAIL write_done got=%b exp=%b", {ms_awvalid, ms_wvalid, busy, done, rd_data}, 8'b0_0_1_1_1010);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL write_idle got=%b exp=00", {busy, done});
            n_bad++;
        end
    endtask

    // Read wins over simultaneous write; a write while busy is ignored.
    task automatic test_rd_wr_collision();
        sm_arready = 1'b0; sm_rvalid = 1'b0;
        req_rd = 1'b1; req_wr = 1'b1; req_addr = 4'h7; req_wdata = 4'h9;
        tick();
        req_rd = 1'b0;
        n_cmp++;
        if ({ms_arvalid, ms_araddr, ms_awvalid, ms_wvalid} !== 7'b1_0111_0_0) begin
            $display("FAIL both_req got=%b exp=%b", {ms_arvalid, ms_araddr, ms_awvalid, ms_wvalid}, 7'b1_0111_0_0);
            n_bad++;
        end
        tick();
        req_wr = 1'b0;
        n_cmp++;
        if ({ms_arvalid, ms_awvalid, ms_wvalid} !== 3'b100) begin
            $display("FAIL busy_wr got=%b exp=100", {ms_arvalid, ms_awvalid, ms_wvalid});
            n_bad++;
        end
        sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'h6;
        tick();
        tick();
        n_cmp++;
        if ({done, rd_data} !== 5'b1_0110) begin
            $display("FAIL both_done got=%b exp=10110", {done, rd_data});
            n_bad++;
        end
        tick();
        tick();
        n_cmp++;
        if ({busy, ms_awvalid, ms_wvalid} !== 3'b000) begin
            $display("FAIL both_after got=%b exp=000", {busy, ms_awvalid, ms_wvalid});
            n_bad++;
        end
    endtask

    // Minimum-latency write followed directly by a read issued as soon as IDLE returns.
    task automatic test_back_to_back();
        sm_awready = 1'b1; sm_wready = 1'b1; sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'h2;
        req_wr = 1'b1; req_addr = 4'h1; req_wdata = 4'h4;
        tick();
        req_wr = 1'b0;
        n_cmp++;
        if ({ms_awvalid, ms_wvalid, done} !== 3'b110) begin
            $display("FAIL b2b_w1 got=%b exp=110", {ms_awvalid, ms_wvalid, done});
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({ms_awvalid, ms_wvalid, busy, done} !== 4'b0011) begin
            $display("FAIL b2b_wdone got=%b exp=0011", {ms_awvalid, ms_wvalid, busy, done});
            n_bad++;
        end
        req_rd = 1'b1; req_addr = 4'hE;
        tick();
        n_cmp++;
        if ({ms_arvalid, busy, done} !== 3'b000) begin
            $display("FAIL b2b_done_ignores_req got=%b exp=000", {ms_arvalid, busy, done});
            n_bad++;
        end
        tick();
        req_rd = 1'b0;
        n_cmp++;
        if ({ms_arvalid, ms_araddr} !== 5'b1_1110) begin
            $display("FAIL b2b_rd got=%b exp=11110", {ms_arvalid, ms_araddr});
            n_bad++;
        end
        tick();
        tick();
        n_cmp++;
        if ({done, rd_data} !== 5'b1_0010) begin
            $display("FAIL b2b_rdone got=%b exp=10010", {done, rd_data});
            n_bad++;
        end
        tick();
    endtask

    // Reset during R aborts without a done pulse; next read runs normally.
    task automatic test_reset_mid();
        sm_arready = 1'b1; sm_rvalid = 1'b0;
        req_rd = 1'b1; req_addr = 4'h2;
        tick();
        req_rd = 1'b0;
        tick();
        n_cmp++;
        if ({ms_rready, busy} !== 2'b11) begin
            $display("FAIL mid_in_r got=%b exp=11", {ms_rready, busy});
            n_bad++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            $display("FAIL mid_async got=%h exp=%h", all_outs(), 23'd0);
            n_bad++;
        end
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL mid_no_done got=%b exp=00", {done, busy});
            n_bad++;
        end
        sm_rvalid = 1'b1; sm_rdata = 4'hD;
        req_rd = 1'b1; req_addr = 4'h4;
        tick();
        req_rd = 1'b0;
        n_cmp++;
        if ({ms_arvalid, ms_araddr} !== 5'b1_0100) begin
            $display("FAIL mid_restart got=%b exp=10100", {ms_arvalid, ms_araddr});
            n_bad++;
        end
        tick();
        tick();
        n_cmp++;
        if ({done, rd_data, err} !== 6'b1_1101_0) begin
            $display("FAIL mid_restart_done got=%b exp=111010", {done, rd_data, err});
            n_bad++;
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        sm_arready = 1'b0; sm_rdata = 4'h0;
        req_rd = 1'b1; req_addr = 4'h8;
        tick();
        req_rd = 1'b0;
        n = 0;
`ifdef AXI_MASTER_SEQ_TIMEOUT_EN
        while (ms_arvalid && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 255) begin
            $display("FAIL to_arvalid_cycles got=%0d exp=255", n);
            n_bad++;
        end
        n_cmp++;
        if ({ms_arvalid, done, err, rd_data} !== 7'b0_1_1_1101) begin
            $display("FAIL to_drop got=%b exp=%b", {ms_arvalid, done, err, rd_data}, 7'b0_1_1_1101);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({busy, done, err} !== 3'b001) begin
            $display("FAIL to_sticky got=%b exp=001", {busy, done, err});
            n_bad++;
        end
`else
        while (n < 300) begin
            tick();
            n++;
            if (!ms_arvalid || done || err) break;
        end
        n_cmp++;
        if ({ms_arvalid, done, err, busy} !== 4'b1001) begin
            $display("FAIL no_to_hold got=%b exp=1001 after=%0d", {ms_arvalid, done, err, busy}, n);
            n_bad++;
        end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({err, ms_arvalid, busy} !== 3'b000) begin
            $display("FAIL to_reset_clear got=%b exp=000", {err, ms_arvalid, busy});
            n_bad++;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; req_addr = 4'h0; req_wdata = 4'h0;
        sm_arready = 1'b0; sm_rvalid = 1'b0; sm_rdata = 4'h0;
        sm_awready = 1'b0; sm_wready = 1'b0;
        test_reset();
        test_read();
        test_write_delayed();
        test_rd_wr_collision();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
